// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix result RAM datapath: widths, address stride,
// default output buffer depth and the read-back FSM state type.
package matrix_pkg;
  localparam int ADDR_W          = 12;
  localparam int DATA_W          = 32;
  localparam int SUM_W           = 20;
  localparam int CNT_W           = 10;
  localparam int ADDR_STRIDE     = 4;
  localparam int FIFO_DEPTH_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;
endpackage

// File: rtl/res_rd_if.sv
// Result stream port between res_rd and the host/UART result sink.
// Handshake: a word transfers in any cycle where sum_valid & sum_ready; once
// sum_valid rises, sum_valid and sum_out hold until that transfer happens.
interface res_rd_if;
  import matrix_pkg::*;
  logic [SUM_W-1:0] sum_out;
  logic             sum_valid;
  logic             sum_ready;

  modport master (output sum_out, output sum_valid, input sum_ready);
  modport slave  (input sum_out, input sum_valid, output sum_ready);
endinterface

// File: rtl/res_rd_fifo.sv
// Small synchronous FIFO buffering stripped result sums; DEPTH must be a power of 2.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module res_rd_fifo
  import matrix_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int W     = SUM_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE_C   = (PW+1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/res_rd.sv
// Result RAM read-back: fetches word_cnt words from base_addr, strips each to its sum
// and streams it out. Optional RES_RD_OVF_CHECK_EN adds a sticky ovf flag for nonzero upper bits.
module res_rd
  import matrix_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  output logic [ADDR_W-1:0] r_addr,
  output logic              ren,
  input  logic [DATA_W-1:0] dataRAM,
  res_rd_if.master          sum_if,
  output logic              busy,
  output logic              done,
`ifdef RES_RD_OVF_CHECK_EN
  output logic              ovf,
`endif
  output rd_state_t         dbg_state
);
  localparam int PW = $clog2(FIFO_DEPTH);

  rd_state_t         state, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  left_q;
  logic              inflight_q;
  logic              done_q;
  logic              fifo_empty;
  logic              fifo_full;
  logic [PW:0]       fifo_count;
  logic              pop;
  logic              start_ok;
  int                credit;

  assign pop       = !fifo_empty && sum_if.sum_ready;
  assign start_ok  = (state == IDLE) && start;
  assign sum_if.sum_valid = !fifo_empty;
  assign r_addr    = addr_q;
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign dbg_state = state;

  // Credit counts a slot freed by this cycle's pop, so a full 1-word/cycle stream
  // sustains with only two entries.
  always_comb begin
    credit = FIFO_DEPTH - int'(fifo_count) + int'(pop) - int'(inflight_q);
  end

  always_comb begin
    state_d = state;
    ren     = 1'b0;
    case (state)
      IDLE: begin
        if (start && word_cnt != '0) state_d = READ;
      end
      READ: begin
        ren = (credit > 0);
        if (ren && left_q == CNT_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && fifo_count == (PW+1)'(1) && !inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      left_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_d;
      inflight_q <= ren;
      done_q     <= (start_ok && word_cnt == '0) || (state == DRAIN && state_d == IDLE);
      if (start_ok && word_cnt != '0) begin
        addr_q <= {base_addr[ADDR_W-1:2], 2'b00};
        left_q <= word_cnt;
      end else if (ren) begin
        addr_q <= addr_q + ADDR_W'(ADDR_STRIDE);
        left_q <= left_q - CNT_W'(1);
      end
    end
  end

  res_rd_fifo #(.DEPTH(FIFO_DEPTH), .W(SUM_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (dataRAM[SUM_W-1:0]),
    .pop   (pop),
    .dout  (sum_if.sum_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  logic unused_bits;
`ifdef RES_RD_OVF_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                                          ovf <= 1'b0;
    else if (start_ok)                                ovf <= 1'b0;
    else if (inflight_q && dataRAM[DATA_W-1:SUM_W] != '0) ovf <= 1'b1;
  end
  assign unused_bits = ^{base_addr[1:0], fifo_full};
`else
  assign unused_bits = ^{base_addr[1:0], fifo_full, dataRAM[DATA_W-1:SUM_W]};
`endif
endmodule
